// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared state encodings, port IDs and counter width for ram_arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_A = 2'b01,
    BUSY_B = 2'b10
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int CNT_W = 16;

endpackage

// File: rtl/ram_arbiter_ram.sv
// rtl/ram_arbiter_ram.sv - single-port word RAM, synchronous write, combinational read
module ram_arbiter_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[addr] <= wdata;
    end
  end

  // Read is combinational so a read granted right after a write sees the new word.
  assign q = mem[addr];

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter in front of one RAM; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  b_req,
  input  logic                  a_we,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [CNT_W-1:0]      conflict_cnt
);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  served_a;
  logic                  served_b;
  logic                  conflict;
  logic                  tie_port;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_served;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served <= PORT_B;
    end else if (a_gnt) begin
      last_served <= PORT_A;
    end else if (b_gnt) begin
      last_served <= PORT_B;
    end
  end

  assign tie_port = (last_served == PORT_A) ? PORT_B : PORT_A;
`else
  assign tie_port = PORT_A;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The state register is the owner: grants and the RAM mux decode straight from it.
  always_comb begin
    state_nxt = state;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          state_nxt = (tie_port == PORT_B) ? BUSY_B : BUSY_A;
        end else if (a_req) begin
          state_nxt = BUSY_A;
        end else if (b_req) begin
          state_nxt = BUSY_B;
        end
      end
      BUSY_A: begin
        a_gnt     = 1'b1;
        ram_we    = a_we;
        ram_addr  = a_addr;
        ram_wdata = a_wdata;
        state_nxt = b_req ? BUSY_B : IDLE;
      end
      BUSY_B: begin
        b_gnt     = 1'b1;
        ram_we    = b_we;
        ram_addr  = b_addr;
        ram_wdata = b_wdata;
        state_nxt = a_req ? BUSY_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign conflict = (a_req & ~a_gnt & ~served_a) | (b_req & ~b_gnt & ~served_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      served_a     <= 1'b0;
      served_b     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= ram_q;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= ram_q;
      end
      served_a <= a_gnt;
      served_b <= b_gnt;
      if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  ram_arbiter_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized scoreboard bench for ram_arbiter
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [15:0]   conflict_cnt;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {bit ga; bit gb; bit rva; bit rvb; bit cnt_chk; logic [15:0] cnt;} exp_t;
  typedef struct {bit known; logic [DW-1:0] data;} rd_t;
  typedef struct {int gap; bit we; logic [AW-1:0] addr; logic [DW-1:0] data;} item_t;

  exp_t          exp_q[$];
  rd_t           a_rq[$], b_rq[$];
  item_t         aq[$], bq[$];
  logic [DW-1:0] mem [int];
  int            glog_port[$], glog_cyc[$];

  // Reference model: who owns the RAM this cycle (0 none, 1 A, 2 B) and what was served last.
  int          m_owner = 0, m_last = 2, cyc = 0, conflicts = 0;
  bit          m_sa = 0, m_sb = 0, m_rva = 0, m_rvb = 0;
  bit          cnt_chk = 1, mono_chk = 0, rel_pending = 0;
  logic [15:0] m_cnt = '0;
  logic [15:0] prev_cnt = '0;
  int          n_tests = 0, n_fail = 0;

  logic [AW-1:0] pool [8] = '{10'h000, 10'h010, 10'h3FF, 10'h155, 10'h2AA, 10'h001, 10'h200, 10'h0F0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input int gap, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
    item_t it;
    it.gap = gap; it.we = we; it.addr = addr; it.data = data;
    return it;
  endfunction

  function automatic int tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return (m_last == 1) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int port);
    rd_t r;
    if (we) begin
      mem[int'(addr)] = data;
    end else begin
      r.known = mem.exists(int'(addr));
      r.data  = r.known ? mem[int'(addr)] : '0;
      if (port == 1) a_rq.push_back(r);
      else b_rq.push_back(r);
    end
  endtask

  // One clock of the model against the inputs currently driven; ends at posedge + 1.
  task automatic step();
    exp_t e;
    bit   ga, gb;
    int   nxt;
    ga = (m_owner == 1);
    gb = (m_owner == 2);
    e.ga = ga; e.gb = gb; e.rva = m_rva; e.rvb = m_rvb; e.cnt = m_cnt; e.cnt_chk = cnt_chk;
    exp_q.push_back(e);
    if ((a_req && !ga && !m_sa) || (b_req && !gb && !m_sb)) begin
      conflicts++;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    if (ga) access(a_we, a_addr, a_wdata, 1);
    if (gb) access(b_we, b_addr, b_wdata, 2);
    m_rva = ga && !a_we;
    m_rvb = gb && !b_we;
    if (ga || gb) begin
      glog_port.push_back(ga ? 1 : 2);
      glog_cyc.push_back(cyc);
      m_last = ga ? 1 : 2;
    end
    if (ga) nxt = b_req ? 2 : 0;
    else if (gb) nxt = a_req ? 1 : 0;
    else if (a_req && b_req) nxt = tie_winner();
    else nxt = a_req ? 1 : (b_req ? 2 : 0);
    m_sa = ga; m_sb = gb; m_owner = nxt; cyc++;
    @(posedge clk);
    #1;
    if (ga) a_req = 1'b0;
    if (gb) b_req = 1'b0;
  endtask

  task automatic run(input int budget);
    item_t it;
    int    n;
    n = 0;
    while ((aq.size() > 0 || bq.size() > 0 || a_req || b_req) && n < budget) begin
      if (!a_req && aq.size() > 0) begin
        it = aq.pop_front();
        if (it.gap > 0) begin
          it.gap--; aq.push_front(it);
        end else begin
          a_req = 1'b1; a_we = it.we; a_addr = it.addr; a_wdata = it.data;
        end
      end
      if (!b_req && bq.size() > 0) begin
        it = bq.pop_front();
        if (it.gap > 0) begin
          it.gap--; bq.push_front(it);
        end else begin
          b_req = 1'b1; b_we = it.we; b_addr = it.addr; b_wdata = it.data;
        end
      end
      step();
      if (rel_pending) begin
        release dut.conflict_cnt;
        rel_pending = 0;
        mono_chk = 1;
      end
      n++;
    end
    check("run_within_budget", 32'(n < budget), 32'(1));
    a_req = 1'b0; b_req = 1'b0; aq.delete(); bq.delete();
    step();
    step();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    rd_t  r;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt_ab", 32'({a_gnt, b_gnt}), 32'({e.ga, e.gb}));
        check("rvalid_ab", 32'({a_rvalid, b_rvalid}), 32'({e.rva, e.rvb}));
        if (e.cnt_chk) check("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
      end
      if (a_rvalid && a_rq.size() > 0) begin
        r = a_rq.pop_front();
        if (r.known) check("a_rdata", a_rdata, r.data);
      end
      if (b_rvalid && b_rq.size() > 0) begin
        r = b_rq.pop_front();
        if (r.known) check("b_rdata", b_rdata, r.data);
      end
      if (mono_chk) check("cnt_no_wrap", 32'(conflict_cnt >= prev_cnt), 32'(1));
      prev_cnt = conflict_cnt;
    end
  end

  initial begin
    int c0;
    int na, nb, alt;
    #2;
    check("rst_a_gnt", 32'(a_gnt), 32'(0));
    check("rst_b_gnt", 32'(b_gnt), 32'(0));
    check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'(0));
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'(0));
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write then read back on port A.
    glog_port.delete(); glog_cyc.delete(); c0 = cyc;
    aq.push_back(mk(0, 1'b1, 10'h010, 32'h1234_5678));
    aq.push_back(mk(0, 1'b0, 10'h010, 32'h0));
    run(50);
    check("wr_rd_a_rdata", a_rdata, 32'h1234_5678);
    check("wr_rd_gnt1_cycle", 32'(glog_cyc[0] - c0), 32'(1));
    check("wr_rd_gnt2_cycle", 32'(glog_cyc[1] - c0), 32'(3));

    // Simultaneous reads from IDLE.
    glog_port.delete(); glog_cyc.delete();
    aq.push_back(mk(0, 1'b0, 10'h010, 32'h0));
    bq.push_back(mk(0, 1'b0, 10'h010, 32'h0));
    run(50);
`ifdef ARB_ROUND_ROBIN_EN
    check("tie_first_port", 32'(glog_port[0]), 32'(2));
    check("tie_second_port", 32'(glog_port[1]), 32'(1));
`else
    check("tie_first_port", 32'(glog_port[0]), 32'(1));
    check("tie_second_port", 32'(glog_port[1]), 32'(2));
`endif

    // Two continuous requesters alternate.
    glog_port.delete(); glog_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      aq.push_back(mk(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom));
      bq.push_back(mk(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom));
    end
    run(100);
    na = 0; nb = 0; alt = 1;
    foreach (glog_port[i]) begin
      if (glog_port[i] == 1) na++; else nb++;
      if (i > 0 && glog_port[i] == glog_port[i-1]) alt = 0;
    end
    check("cont_a_grants", 32'(na), 32'(5));
    check("cont_b_grants", 32'(nb), 32'(5));
    check("cont_no_idle", 32'(glog_cyc[glog_cyc.size()-1] - glog_cyc[0]), 32'(9));
    check("cont_alternate", 32'(alt), 32'(1));

    // B writes while A waits, A then reads the fresh word.
    bq.push_back(mk(0, 1'b1, 10'h3FF, 32'hDEAD_BEEF));
    aq.push_back(mk(1, 1'b0, 10'h3FF, 32'h0));
    run(50);
    check("b_wr_a_rd_rdata", a_rdata, 32'hDEAD_BEEF);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      aq.push_back(mk($urandom_range(0, 3), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom));
      bq.push_back(mk($urandom_range(0, 3), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom));
    end
    run(3000);

    // Reset during a B read grant.
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h010;
    step();
    #2;
    check("pre_rst_b_gnt", 32'(b_gnt), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_b_gnt", 32'(b_gnt), 32'(0));
    check("mid_rst_cnt", 32'(conflict_cnt), 32'(0));
    check("mid_rst_b_rdata", b_rdata, 32'h0);
    b_req = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_b_rvalid", 32'(b_rvalid), 32'(0));
    check("mid_rst_b_rdata_hold", b_rdata, 32'h0);
    exp_q.delete(); a_rq.delete(); b_rq.delete();
    m_owner = 0; m_last = 2; m_sa = 0; m_sb = 0; m_rva = 0; m_rvb = 0; m_cnt = '0;
    rst = 1'b0;
    step();
    step();

    // Saturation under sustained contention.
    cnt_chk = 0;
    aq.push_back(mk(0, 1'b0, pool[$urandom_range(0, 7)], 32'h0));
    bq.push_back(mk(0, 1'b0, pool[$urandom_range(0, 7)], 32'h0));
    for (int i = 0; i < 40; i++) begin
      aq.push_back(mk(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom));
      bq.push_back(mk(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom));
    end
    force dut.conflict_cnt = 16'hFFF0;
    rel_pending = 1;
    run(2000);
    mono_chk = 0;
    check("cnt_saturated", 32'(conflict_cnt), 32'h0000_FFFF);

    check("a_reads_drained", 32'(a_rq.size()), 32'(0));
    check("b_reads_drained", 32'(b_rq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
